// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter fed by a circular byte FIFO

module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic [CW-1:0] count_next;

  // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push_ok = push && !full;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

module uart_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   tx
);
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next, bit_nxt;
  logic [7:0]       shift, shift_next;
  logic             tx_next;
  logic             pop;
  logic [7:0]       head;
  logic             have_byte;
  logic             bit_done;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  assign have_byte = (count != '0);
  assign bit_done  = (baud_cnt == CNT_LAST);
  assign bit_nxt   = bit_idx + 3'd1;
  assign busy      = (state != IDLE) || have_byte;

  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    tx_next       = tx;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        if (have_byte) begin
          pop        = 1'b1;
          shift_next = head;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          bit_idx_next  = 3'd0;
          tx_next       = shift[0];
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_idx_next = bit_nxt;
            tx_next      = shift[bit_nxt];
          end
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          // Chain straight into the next start bit so queued frames have no gap.
          if (have_byte) begin
            pop        = 1'b1;
            shift_next = head;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-level model

module tb_uart_tx;
  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 8;
  localparam int DIV      = 10;
  localparam int FRAME    = 10 * DIV;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       full, busy, tx;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .busy    (busy),
    .count   (count),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Frame-level model: a byte queue plus the edge at which the current frame began.
  logic [7:0] mq[$];
  logic [7:0] accepted[$];
  logic [7:0] decoded[$];
  int         cyc = 0;
  int         fstart = 0;
  bit         in_frame = 0;
  logic [7:0] cur = 8'd0;
  int         m_pre;
  int         tb_cyc = 0;

  always @(posedge clk) tb_cyc++;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      in_frame = 0;
      cyc = 0;
    end else begin
      cyc++;
      if (in_frame && (cyc - fstart) == FRAME) in_frame = 0;
      m_pre = mq.size();
      if (!in_frame && m_pre > 0) begin
        cur = mq.pop_front();
        fstart = cyc;
        in_frame = 1;
      end
      if (wr_en && m_pre < DEPTH) begin
        mq.push_back(wr_data);
        accepted.push_back(wr_data);
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!in_frame) return 1'b1;
    k = (cyc - fstart) / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      check("tx", tx, exp_tx());
      check("count", count, mq.size());
      check("full", full, mq.size() == DEPTH);
      check("busy", busy, in_frame || mq.size() > 0);
    end
  end

  // Independent line receiver sampling mid-bit.
  bit         dec_active = 0;
  int         dec_cnt = 0;
  int         dec_k;
  logic [7:0] dec_byte = 8'd0;

  always @(negedge clk) begin
    if (!rstn) begin
      dec_active = 0;
    end else if (!dec_active) begin
      if (tx === 1'b0) begin
        dec_active = 1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % DIV == DIV / 2) begin
        dec_k = dec_cnt / DIV;
        if (dec_k == 0) check("start_bit", tx, 0);
        else if (dec_k <= 8) dec_byte[dec_k-1] = tx;
        else begin
          check("stop_bit", tx, 1);
          decoded.push_back(dec_byte);
          dec_active = 0;
        end
      end
    end
  end

  task automatic drive(input bit en, input logic [7:0] d);
    @(negedge clk);
    wr_en = en;
    wr_data = d;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy !== 1'b0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("idle_timeout", g < 3000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stream();
    wait_idle();
    check("stream_len", decoded.size(), accepted.size());
    for (int i = 0; i < decoded.size() && i < accepted.size(); i++)
      check("stream_byte", decoded[i], accepted[i]);
    decoded.delete();
    accepted.delete();
  endtask

  task automatic wait_elapsed(input int e, input string name);
    int g = 0;
    while (!(in_frame && (cyc - fstart) == e) && g < 400) begin
      @(negedge clk);
      g++;
    end
    check(name, g < 400, 1);
  endtask

  initial begin
    logic [9:0] pat;
    int t0;
    int lows;

    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    int t0;
    int lows;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    #2 rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Single 0xA5 frame against a hand-written line pattern.
    pat = 10'b1_10100101_0;
    drive(1, 8'hA5);
    drive(0, 8'h00);
    check("a5_count", count, 1);
    check("a5_tx_before", tx, 1);
    @(negedge clk);
    check("a5_tx_fall", tx, 0);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? DIV / 2 : DIV) @(negedge clk);
      check("a5_bit", tx, pat[k]);
    end
    repeat (DIV / 2 - 1) @(negedge clk);
    check("a5_busy_stop", busy, 1);
    @(negedge clk);
    check("a5_busy_fall", busy, 0);
    check_stream();

    // Three consecutive pushes form one gapless 300-cycle burst.
    drive(1, 8'h01);
    drive(1, 8'h02);
    check("b3_count1", count, 1);
    t0 = tb_cyc;
    drive(1, 8'h03);
    check("b3_count2", count, 1);
    drive(0, 8'h00);
    check("b3_count3", count, 2);
    while (busy === 1'b1 && tb_cyc - t0 < 500) @(negedge clk);
    check("b3_cycles", tb_cyc - t0, 1 + 3 * FRAME);
    check_stream();

    // One frame in flight plus nine pushes: eight fit, the ninth is dropped.
    drive(1, 8'($urandom));
    repeat (3) drive(0, 8'h00);
    for (int i = 0; i < 9; i++) drive(1, 8'($urandom));
    drive(0, 8'h00);
    check("ovf_count", count, 8);
    check("ovf_full", full, 1);
    wait_idle();
    check("ovf_frames", decoded.size(), 9);
    check_stream();

    // Push while full on the very edge that the stop bit pops the next byte.
    drive(1, 8'($urandom));
    drive(0, 8'h00);
    for (int i = 0; i < 8; i++) drive(1, 8'($urandom));
    drive(0, 8'h00);
    check("pp_full_before", full, 1);
    wait_elapsed(FRAME - 1, "pp_sync");
    wr_en = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    check("pp_count", count, 7);
    check("pp_full_after", full, 0);
    check_stream();

    // Asynchronous reset in the middle of data bit 3 with four bytes queued.
    drive(1, 8'h00);
    for (int i = 0; i < 4; i++) drive(1, 8'($urandom));
    drive(0, 8'h00);
    wait_elapsed(4 * DIV + DIV / 2, "rst_sync");
    check("mid_tx_low", tx, 0);
    check("mid_count", count, 4);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_count", count, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    decoded.delete();
    accepted.delete();
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("post_rst_quiet", lows, 0);

    // Random pushes with random gaps, many more than DEPTH in total.
    for (int i = 0; i < 30; i++) begin
      drive(1, 8'($urandom));
      repeat ($urandom_range(0, 60)) drive(0, 8'h00);
    end
    drive(0, 8'h00);
    check_stream();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
